// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall controller with multi-cycle EX sequencer and stall statistics
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        ex_mc_start,
    input  logic [3:0]  ex_mc_cycles,
    input  logic        flush,
    output logic [5:0]  stall,
    output logic        mc_busy,
    output logic        mc_done,
    output logic [31:0] stall_cycles,
    output logic [15:0] bubble_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    logic [1:0] state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       stallreq_ex;

    // The start cycle itself stalls, so EX is held for exactly N cycles and advances in DONE.
    always_comb begin
        stallreq_ex = ((state == IDLE) && ex_mc_start && (ex_mc_cycles != 4'd0) && !flush)
                      || (state == RUN);
    end

    always_comb begin
        stall = STALL_NONE;
        if (rst || flush)      stall = STALL_NONE;
        else if (stallreq_mem) stall = STALL_MEM;
        else if (stallreq_ex)  stall = STALL_EX;
        else if (stallreq_id)  stall = STALL_ID;
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (ex_mc_start && (ex_mc_cycles >= 4'd2)) begin
                    next_state = RUN;
                    next_cnt   = ex_mc_cycles - 4'd1;
                end else if (ex_mc_start && (ex_mc_cycles == 4'd1)) begin
                    next_state = DONE;
                end
            end
            // The functional unit keeps counting through memory waits.
            RUN: begin
                next_cnt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    next_state = DONE;
                    next_cnt   = 4'd0;
                end
            end
            DONE: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
        if (flush) begin
            next_state = IDLE;
            next_cnt   = 4'd0;
        end
    end

    always_comb begin
        mc_busy = !rst && (state == RUN);
        mc_done = !rst && (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            stall_cycles <= 32'd0;
            bubble_cnt   <= 16'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if ((stall != STALL_NONE) && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (stall[2] && !stall[3])
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        ex_mc_start = 1'b0;
    logic [3:0]  ex_mc_cycles = 4'd0;
    logic        flush = 1'b0;
    logic [5:0]  stall;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] stall_cycles;
    logic [15:0] bubble_cnt;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .flush        (flush),
        .stall        (stall),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cycles (stall_cycles),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] stall;
        logic       busy;
        logic       done;
        logic       pre;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_sc = 32'd0;
    logic [15:0] exp_bc = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic cyc(input logic r, input logic id, input logic mem, input logic st,
                       input logic [3:0] n, input logic fl,
                       input logic [5:0] es, input logic eb, input logic ed,
                       input logic pre = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = id; stallreq_mem = mem;
        ex_mc_start = st; ex_mc_cycles = n; flush = fl;
        e.rst = r; e.stall = es; e.busy = eb; e.done = ed; e.pre = pre;
        exp_q.push_back(e);
    endtask

    // Compare mid-cycle, then advance the counter model for the coming edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("mc_busy", 32'(mc_busy), 32'(e.busy));
            chk("mc_done", 32'(mc_done), 32'(e.done));
            chk("stall_cycles", stall_cycles, exp_sc);
            chk("bubble_cnt", 32'(bubble_cnt), 32'(exp_bc));
            if (e.pre) begin
                force dut.stall_cycles = 32'hFFFF_FFFE;
                force dut.bubble_cnt = 16'hFFFF;
                #1;
                release dut.stall_cycles;
                release dut.bubble_cnt;
                exp_sc = 32'hFFFF_FFFE;
                exp_bc = 16'hFFFF;
            end
            if (e.rst) begin
                exp_sc = 32'd0;
                exp_bc = 16'd0;
            end else begin
                if (e.stall != 6'd0 && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
                if (e.stall[2] && !e.stall[3]) exp_bc = exp_bc + 16'd1;
            end
        end
    end

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SM = 6'b011111;
    localparam logic [5:0] SE = 6'b001111;
    localparam logic [5:0] SI = 6'b000111;

    initial begin
        //   rst id mem st  n     fl  stall busy done
        cyc(1, 1, 1, 1, 4'd4, 0, S0, 0, 0);
        cyc(1, 0, 1, 1, 4'd1, 0, S0, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        // load-use hazard
        cyc(0, 1, 0, 0, 4'd0, 0, SI, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        // 4-cycle op; id request and a restart inside RUN change nothing
        cyc(0, 0, 0, 1, 4'd4, 0, SE, 0, 0);
        cyc(0, 1, 0, 0, 4'd0, 0, SE, 1, 0);
        cyc(0, 0, 0, 1, 4'd2, 0, SE, 1, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, SE, 1, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 1);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        // memory wait overlapping a 3-cycle op
        cyc(0, 0, 0, 1, 4'd3, 0, SE, 0, 0);
        cyc(0, 0, 1, 0, 4'd0, 0, SM, 1, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, SE, 1, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 1);
        // flush mid-op, then N=1
        cyc(0, 0, 0, 1, 4'd8, 0, SE, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, SE, 1, 0);
        cyc(0, 0, 0, 0, 4'd0, 1, S0, 1, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        cyc(0, 0, 0, 1, 4'd1, 0, SE, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 1);
        // flush beats start in the same cycle
        cyc(0, 0, 0, 1, 4'd3, 1, S0, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        // N=0 ignored; N=1 with a start during DONE ignored
        cyc(0, 0, 0, 1, 4'd0, 0, S0, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        cyc(0, 0, 0, 1, 4'd1, 0, SE, 0, 0);
        cyc(0, 0, 0, 1, 4'd4, 0, S0, 0, 1);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        // reset mid-RUN aborts without a done pulse
        cyc(0, 0, 0, 1, 4'd4, 0, SE, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, SE, 1, 0);
        cyc(1, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        // counter limits after preload
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0, 1'b1);
        cyc(0, 1, 0, 0, 4'd0, 0, SI, 0, 0);
        cyc(0, 1, 0, 0, 4'd0, 0, SI, 0, 0);
        cyc(0, 1, 0, 0, 4'd0, 0, SI, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, S0, 0, 0);
        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("final_stall_cycles", stall_cycles, 32'hFFFF_FFFF);
        chk("final_bubble_cnt", 32'(bubble_cnt), 32'h0000_0002);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
